// File: rtl/chart_pkg.sv
// Shared chart definitions: ROM geometry, end-of-chart marker, sequencer states
// and word helpers used by the chart ROM, the sequencer and the scroll engine.
package chart_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;

  localparam logic [DATA_W-1:0] END_WORD  = 16'hFFFF;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DONE
  } seq_state_t;

  function automatic logic [LANES-1:0] laneMask(input logic [DATA_W-1:0] word);
    return word[LANES-1:0];
  endfunction

  function automatic logic isEndWord(input logic [DATA_W-1:0] word);
    return word == END_WORD;
  endfunction

endpackage

// File: rtl/chart_sequencer_if.sv
// Bundle of control, chart-ROM and note-handshake signals around the sequencer;
// master is the sequencer side, slave is the ROM/consumer/controller side.
interface chart_sequencer_if;
  import chart_pkg::*;

  logic              start;
  logic              abort;
  logic              pause;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              note_valid;
  logic [LANES-1:0]  note_lanes;
  logic              note_ready;
  logic [ADDR_W-1:0] step_index;
  logic              playing;
  logic              done;
  logic              overrun;

  modport master (
    input  start, abort, pause, rom_data, note_ready,
    output rom_addr, note_valid, note_lanes, step_index, playing, done, overrun
  );

  modport slave (
    output start, abort, pause, rom_data, note_ready,
    input  rom_addr, note_valid, note_lanes, step_index, playing, done, overrun
  );

endinterface

// File: rtl/chart_sequencer_step_timer.sv
// Step timer: counts enabled cycles and pulses tick on the last one, then restarts.
// TICKS_PER_STEP must be at least 2; the FETCH cycle accounts for the remaining one.
module step_timer #(
  parameter int TICKS_PER_STEP = 6_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(TICKS_PER_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 2);

  logic [CNT_W-1:0] r_count;

  assign tick = en && (r_count == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Chart sequencer: walks the chart ROM one step per timer period and presents
// each non-rest word as a lane-mask note event on a valid/ready handshake.
module chart_sequencer
  import chart_pkg::*;
#(
  parameter int TICKS_PER_STEP = 6_250_000
) (
  input  logic              clk,
  input  logic              rst_n,
  chart_sequencer_if.master bus
);

  seq_state_t        r_state;
  seq_state_t        w_stateNext;
  logic [ADDR_W-1:0] r_romAddr;
  logic [ADDR_W-1:0] w_romAddrNext;
  logic              r_noteValid;
  logic [LANES-1:0]  r_noteLanes;
  logic [ADDR_W-1:0] r_stepIndex;
  logic              r_overrun;

  logic              w_tick;
  logic              w_timerEn;
  logic              w_timerClear;
  logic              w_startAccept;
  logic              w_noteLoad;
  logic [LANES-1:0]  w_fetchMask;

  assign w_fetchMask = laneMask(bus.rom_data);
  assign w_timerEn   = (r_state == ST_WAIT) && !bus.pause;

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_stepTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_timerClear),
    .en    (w_timerEn),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Abort outranks everything, including a simultaneous start.
  always_comb begin
    w_stateNext   = r_state;
    w_romAddrNext = r_romAddr;
    w_timerClear  = 1'b0;
    w_startAccept = 1'b0;
    w_noteLoad    = 1'b0;
    if (bus.abort) begin
      w_stateNext   = ST_IDLE;
      w_romAddrNext = '0;
      w_timerClear  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            w_startAccept = 1'b1;
            w_stateNext   = ST_FETCH;
            w_romAddrNext = '0;
            w_timerClear  = 1'b1;
          end
        end
        ST_FETCH: begin
          if (isEndWord(bus.rom_data)) begin
            w_stateNext = ST_DONE;
          end else begin
            w_stateNext = ST_WAIT;
            w_noteLoad  = (w_fetchMask != '0);
          end
        end
        ST_WAIT: begin
          if (w_tick) begin
            if (r_romAddr == ADDR_LAST) begin
              w_stateNext = ST_DONE;
            end else begin
              w_stateNext   = ST_FETCH;
              w_romAddrNext = r_romAddr + ADDR_W'(1);
            end
          end
        end
        default: begin
          w_stateNext   = ST_IDLE;
          w_romAddrNext = '0;
          w_timerClear  = 1'b1;
        end
      endcase
    end
  end

  // A freshly fetched note always replaces the pending one; overrun records
  // that the replaced note was never accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_romAddr   <= '0;
      r_noteValid <= 1'b0;
      r_noteLanes <= '0;
      r_stepIndex <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_romAddr <= w_romAddrNext;
      if (bus.abort) begin
        r_noteValid <= 1'b0;
      end else if (w_noteLoad) begin
        r_noteValid <= 1'b1;
        r_noteLanes <= w_fetchMask;
        r_stepIndex <= r_romAddr;
        if (r_noteValid && !bus.note_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_noteValid && bus.note_ready) begin
        r_noteValid <= 1'b0;
      end
      if (w_startAccept) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.rom_addr   = r_romAddr;
  assign bus.note_valid = r_noteValid;
  assign bus.note_lanes = r_noteLanes;
  assign bus.step_index = r_stepIndex;
  assign bus.overrun    = r_overrun;
  assign bus.playing    = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  assign bus.done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: a step-countdown model of playback checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_chart_sequencer;
  import chart_pkg::*;

  localparam int T = 4;

  logic clk;
  logic rst_n;
  logic [15:0] rom [256];

  chart_sequencer_if bus();

  assign bus.rom_data = rom[bus.rom_addr];

  chart_sequencer #(
    .TICKS_PER_STEP(T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cycleCount = 0;
  int noteLanes[$];
  int noteStep[$];
  int noteCycle[$];

  bit       mPlaying;
  bit       mDone;
  bit       mValid;
  bit       mOverrun;
  logic [7:0] mAddr;
  logic [7:0] mStep;
  logic [3:0] mLanes;
  int       mWaitLeft;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(posedge clk) begin
    if (rst_n && bus.note_valid && bus.note_ready) begin
      noteLanes.push_back(int'(bus.note_lanes));
      noteStep.push_back(int'(bus.step_index));
      noteCycle.push_back(cycleCount);
    end
  end

  // Model: wl counts cycles left until the next fetch; a fetch happens when it is 0.
  always @(posedge clk or negedge rst_n) begin : modelProc
    bit pl, dn, vl, ov, noteNow;
    logic [7:0] ad;
    int wl;
    logic [15:0] word;
    logic [3:0] newMask;
    if (!rst_n) begin
      mPlaying  <= 1'b0;
      mDone     <= 1'b0;
      mValid    <= 1'b0;
      mOverrun  <= 1'b0;
      mAddr     <= '0;
      mStep     <= '0;
      mLanes    <= '0;
      mWaitLeft <= 0;
    end else begin
      pl = mPlaying; dn = mDone; ad = mAddr; wl = mWaitLeft;
      vl = mValid; ov = mOverrun; noteNow = 1'b0; newMask = '0;
      if (bus.abort) begin
        pl = 0; dn = 0; ad = 0; wl = 0;
      end else if (!pl) begin
        if (bus.start) begin
          pl = 1; dn = 0; ad = 0; wl = 0; ov = 0;
        end
      end else if (wl == 0) begin
        word = rom[ad];
        if (word == 16'hFFFF) begin
          pl = 0; dn = 1;
        end else begin
          wl = T - 1;
          newMask = word[3:0];
          noteNow = (newMask != 4'd0);
        end
      end else if (!bus.pause) begin
        wl--;
        if (wl == 0) begin
          if (ad == 8'd255) begin
            pl = 0; dn = 1;
          end else begin
            ad++;
          end
        end
      end
      if (bus.abort) begin
        vl = 0;
      end else if (noteNow) begin
        if (vl && !bus.note_ready) ov = 1;
        vl = 1;
        mLanes <= newMask;
        mStep  <= ad;
      end else if (vl && bus.note_ready) begin
        vl = 0;
      end
      mPlaying  <= pl;
      mDone     <= dn;
      mAddr     <= ad;
      mWaitLeft <= wl;
      mValid    <= vl;
      mOverrun  <= ov;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cyc_rom_addr", bus.rom_addr, mAddr);
      checkOutput("cyc_playing", bus.playing, mPlaying);
      checkOutput("cyc_done", bus.done, mDone);
      checkOutput("cyc_note_valid", bus.note_valid, mValid);
      if (mValid) checkOutput("cyc_note_lanes", bus.note_lanes, mLanes);
      checkOutput("cyc_step_index", bus.step_index, mStep);
      checkOutput("cyc_overrun", bus.overrun, mOverrun);
    end
  end

  task automatic applyStimulus(input bit s, input bit a);
    @(negedge clk);
    bus.start = s;
    bus.abort = a;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_budget", bus.done, 1);
  endtask

  task automatic clearNotes();
    noteLanes.delete();
    noteStep.delete();
    noteCycle.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rom_addr"}, bus.rom_addr, 0);
    checkOutput({tag, "_note_valid"}, bus.note_valid, 0);
    checkOutput({tag, "_note_lanes"}, bus.note_lanes, 0);
    checkOutput({tag, "_step_index"}, bus.step_index, 0);
    checkOutput({tag, "_playing"}, bus.playing, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin : stim
    bit found;
    int errs;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pause = 1'b0;
    bus.note_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    #2 rst_n = 1'b0;
    #10;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic playback");
    rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0000; rom[3] = 16'hFFFF;
    clearNotes();
    applyStimulus(1, 0);
    waitDone(60);
    checkOutput("basic_note_count", noteLanes.size(), 2);
    if (noteLanes.size() >= 2) begin
      checkOutput("basic_note0_lanes", noteLanes[0], 1);
      checkOutput("basic_note0_step", noteStep[0], 0);
      checkOutput("basic_note1_lanes", noteLanes[1], 2);
      checkOutput("basic_note1_step", noteStep[1], 1);
      checkOutput("basic_note_gap", noteCycle[1] - noteCycle[0], T);
    end

    $display("[TB] backpressure");
    bus.note_ready = 1'b0;
    clearNotes();
    applyStimulus(1, 0);
    waitDone(60);
    checkOutput("bp_valid", bus.note_valid, 1);
    checkOutput("bp_lanes", bus.note_lanes, 4'b0010);
    checkOutput("bp_step", bus.step_index, 1);
    checkOutput("bp_overrun", bus.overrun, 1);
    bus.note_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_valid_after_accept", bus.note_valid, 0);
    checkOutput("bp_overrun_sticky", bus.overrun, 1);
    applyStimulus(1, 0);
    checkOutput("bp_overrun_cleared", bus.overrun, 0);
    checkOutput("bp_restart_playing", bus.playing, 1);
    applyStimulus(0, 1);
    checkOutput("bp_abort_idle", bus.playing, 0);

    $display("[TB] pause");
    for (int i = 0; i < 4; i++) rom[i] = 16'h0001;
    rom[4] = 16'hFFFF;
    clearNotes();
    applyStimulus(1, 0);
    @(negedge clk);
    @(negedge clk);
    bus.pause = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("pause_addr_hold", bus.rom_addr, 0);
    end
    bus.pause = 1'b0;
    waitDone(80);
    checkOutput("pause_note_count", noteLanes.size(), 4);
    if (noteLanes.size() >= 3) begin
      checkOutput("pause_gap01", noteCycle[1] - noteCycle[0], T + 10);
      checkOutput("pause_gap12", noteCycle[2] - noteCycle[1], T);
    end

    $display("[TB] abort");
    for (int i = 0; i < 10; i++) rom[i] = 16'h0001;
    rom[10] = 16'hFFFF;
    bus.note_ready = 1'b0;
    applyStimulus(1, 0);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (bus.rom_addr == 8'd5 && bus.step_index == 8'd5 && bus.note_valid) found = 1'b1;
    end
    checkOutput("abort_setup_reached", found, 1);
    applyStimulus(1, 1);
    checkOutput("abort_playing", bus.playing, 0);
    checkOutput("abort_note_valid", bus.note_valid, 0);
    checkOutput("abort_rom_addr", bus.rom_addr, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_overrun_kept", bus.overrun, 1);
    bus.note_ready = 1'b1;
    @(negedge clk);
    checkOutput("abort_stays_idle", bus.playing, 0);

    $display("[TB] full length");
    for (int i = 0; i < 256; i++) rom[i] = 16'h0004;
    clearNotes();
    applyStimulus(1, 0);
    waitDone(1300);
    checkOutput("full_note_count", noteLanes.size(), 256);
    errs = 0;
    foreach (noteLanes[i]) begin
      if (noteStep[i] != i || noteLanes[i] != 4) errs++;
    end
    checkOutput("full_step_sequence_errs", errs, 0);
    checkOutput("full_rom_addr", bus.rom_addr, 255);
    repeat (8) @(negedge clk);
    checkOutput("full_no_wrap_addr", bus.rom_addr, 255);
    checkOutput("full_done_held", bus.done, 1);

    $display("[TB] async reset");
    bus.note_ready = 1'b0;
    applyStimulus(1, 0);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (bus.rom_addr == 8'd2) found = 1'b1;
    end
    checkOutput("areset_setup_reached", found, 1);
    checkOutput("areset_pre_playing", bus.playing, 1);
    checkOutput("areset_pre_valid", bus.note_valid, 1);
    checkOutput("areset_pre_overrun", bus.overrun, 1);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("areset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.note_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("areset_idle_after", bus.playing, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
